// File: rtl/cu_fsm_mc.sv
// rtl/cu_fsm_mc.sv - OTTER RV32I multicycle control FSM with ready handshakes and memory watchdog
// Optional interrupt entry state enabled by defining CU_FSM_INTR_EN.
module cu_fsm_mc #(
   parameter int WAIT_MAX     = 16,
   parameter int ILLEGAL_TRAP = 0,
   parameter int WCNT_W       = $clog2(WAIT_MAX + 1)
) (
   input  logic       clk,
   input  logic       FSM_RST_N,
   input  logic [6:0] FSM_opcode,
   input  logic       FSM_imem_ready,
   input  logic       FSM_dmem_ready,
   input  logic       FSM_intr,
   input  logic       FSM_mie,
   output logic       FSM_PCWrite,
   output logic       FSM_regWrite,
   output logic       FSM_memWE2,
   output logic       FSM_memRDEN1,
   output logic       FSM_memRDEN2,
   output logic       FSM_reset,
   output logic       FSM_intTaken,
   output logic       FSM_illegal,
   output logic       FSM_fault,
   output logic [2:0] FSM_state
);

   // WAIT_MAX=0 yields a zero-width counter; keep one bit so the logic stays legal.
   localparam int            CW         = (WCNT_W < 1) ? 1 : WCNT_W;
   localparam logic [CW-1:0] WCNT_LAST  = CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
   localparam logic          TIMEOUT_EN = (WAIT_MAX > 0);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_MEM   = 3'd3,
      ST_WB    = 3'd4,
      ST_INTR  = 3'd5,
      ST_TRAP  = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      OPC_NONE = 2'd0,
      OPC_LD   = 2'd1,
      OPC_ST   = 2'd2
   } opc_t;

   state_t        state_q, state_d;
   opc_t          opc_q, opc_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic [CW-1:0] wcnt_inc;
   logic          wcnt_last;
   state_t        retire_st;

`ifdef CU_FSM_INTR_EN
   assign retire_st = (FSM_intr && FSM_mie) ? ST_INTR : ST_FETCH;
`else
   logic unused_intr;
   assign unused_intr = FSM_intr ^ FSM_mie;
   assign retire_st   = ST_FETCH;
`endif

   assign wcnt_inc  = (wcnt_q != '1) ? wcnt_q + CW'(1) : wcnt_q;
   assign wcnt_last = TIMEOUT_EN && (wcnt_q == WCNT_LAST);
   assign FSM_state = state_q;

   always_ff @(posedge clk or negedge FSM_RST_N) begin
      if (!FSM_RST_N) begin
         state_q <= ST_INIT;
         opc_q   <= OPC_NONE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // The counter only survives self-loops in FETCH/MEM, so every entry starts at zero.
   always_comb begin
      state_d      = state_q;
      opc_d        = opc_q;
      wcnt_d       = '0;
      FSM_PCWrite  = 1'b0;
      FSM_regWrite = 1'b0;
      FSM_memWE2   = 1'b0;
      FSM_memRDEN1 = 1'b0;
      FSM_memRDEN2 = 1'b0;
      FSM_reset    = 1'b0;
      FSM_intTaken = 1'b0;
      FSM_illegal  = 1'b0;
      FSM_fault    = 1'b0;
      case (state_q)
         ST_INIT: begin
            FSM_reset = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_FETCH: begin
            FSM_memRDEN1 = 1'b1;
            if (FSM_imem_ready)  state_d = ST_EXEC;
            else if (wcnt_last)  state_d = ST_TRAP;
            else                 wcnt_d  = wcnt_inc;
         end
         ST_EXEC: begin
            opc_d = OPC_NONE;
            case (FSM_opcode)
               7'b0110111, 7'b0010011, 7'b0110011,
               7'b0010111, 7'b1101111, 7'b1100111: begin
                  FSM_regWrite = 1'b1;
                  FSM_PCWrite  = 1'b1;
                  state_d      = retire_st;
               end
               7'b1100011: begin
                  FSM_PCWrite = 1'b1;
                  state_d     = retire_st;
               end
               7'b0000011: begin
                  FSM_memRDEN2 = 1'b1;
                  opc_d        = OPC_LD;
                  state_d      = ST_MEM;
               end
               7'b0100011: begin
                  FSM_memWE2 = 1'b1;
                  opc_d      = OPC_ST;
                  state_d    = ST_MEM;
               end
               default: begin
                  FSM_illegal = 1'b1;
                  if (ILLEGAL_TRAP != 0) begin
                     state_d = ST_TRAP;
                  end else begin
                     FSM_PCWrite = 1'b1;
                     state_d     = retire_st;
                  end
               end
            endcase
         end
         ST_MEM: begin
            FSM_memRDEN2 = (opc_q == OPC_LD);
            FSM_memWE2   = (opc_q == OPC_ST);
            if (FSM_dmem_ready) begin
               if (opc_q == OPC_ST) begin
                  FSM_PCWrite = 1'b1;
                  state_d     = retire_st;
               end else begin
                  state_d = ST_WB;
               end
            end else if (wcnt_last) begin
               state_d = ST_TRAP;
            end else begin
               wcnt_d = wcnt_inc;
            end
         end
         ST_WB: begin
            FSM_regWrite = 1'b1;
            FSM_PCWrite  = 1'b1;
            state_d      = retire_st;
         end
`ifdef CU_FSM_INTR_EN
         ST_INTR: begin
            FSM_intTaken = 1'b1;
            FSM_PCWrite  = 1'b1;
            state_d      = ST_FETCH;
         end
`endif
         ST_TRAP: begin
            FSM_fault = 1'b1;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_cu_fsm_mc.sv
// tb/tb_cu_fsm_mc.sv - self-checking bench for cu_fsm_mc
module tb_cu_fsm_mc;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   // {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, intTaken, illegal, fault}
   localparam logic [8:0] O_INIT  = 9'b000001000;
   localparam logic [8:0] O_FETCH = 9'b000100000;
   localparam logic [8:0] O_ALU   = 9'b110000000;
   localparam logic [8:0] O_BR    = 9'b100000000;
   localparam logic [8:0] O_LDX   = 9'b000010000;
   localparam logic [8:0] O_STX   = 9'b001000000;
   localparam logic [8:0] O_STR   = 9'b101000000;
   localparam logic [8:0] O_ILL0  = 9'b100000010;
   localparam logic [8:0] O_ILL1  = 9'b000000010;
   localparam logic [8:0] O_TRAP  = 9'b000000001;
   localparam logic [8:0] O_INTR  = 9'b100000100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, imem_ready, dmem_ready, intr, mie;
   logic [6:0] opcode;
   logic       pcw, rw, we2, rd1, rd2, rst_o, itk, ill, flt;
   logic [2:0] st;
   logic       t_pcw, t_rw, t_we2, t_rd1, t_rd2, t_rst, t_itk, t_ill, t_flt;
   logic [2:0] t_st;

   cu_fsm_mc #(.WAIT_MAX(4), .ILLEGAL_TRAP(0)) dut (
      .clk(clk), .FSM_RST_N(rst_n), .FSM_opcode(opcode),
      .FSM_imem_ready(imem_ready), .FSM_dmem_ready(dmem_ready),
      .FSM_intr(intr), .FSM_mie(mie),
      .FSM_PCWrite(pcw), .FSM_regWrite(rw), .FSM_memWE2(we2),
      .FSM_memRDEN1(rd1), .FSM_memRDEN2(rd2), .FSM_reset(rst_o),
      .FSM_intTaken(itk), .FSM_illegal(ill), .FSM_fault(flt), .FSM_state(st)
   );

   cu_fsm_mc #(.WAIT_MAX(16), .ILLEGAL_TRAP(1)) dut_t (
      .clk(clk), .FSM_RST_N(rst_n), .FSM_opcode(opcode),
      .FSM_imem_ready(imem_ready), .FSM_dmem_ready(dmem_ready),
      .FSM_intr(intr), .FSM_mie(mie),
      .FSM_PCWrite(t_pcw), .FSM_regWrite(t_rw), .FSM_memWE2(t_we2),
      .FSM_memRDEN1(t_rd1), .FSM_memRDEN2(t_rd2), .FSM_reset(t_rst),
      .FSM_intTaken(t_itk), .FSM_illegal(t_ill), .FSM_fault(t_flt), .FSM_state(t_st)
   );

   typedef struct {
      logic [6:0] op;
      logic       ir;
      logic       dr;
      logic [2:0] st;
      logic [8:0] out;
      string      name;
   } vec_t;

   typedef struct {
      logic [2:0] st;
      logic [8:0] out;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic add(input logic [6:0] op, input logic ir, input logic dr,
                      input logic [2:0] s, input logic [8:0] o, input string name);
      vec_t v;
      v.op = op; v.ir = ir; v.dr = dr; v.st = s; v.out = o; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic expect_now(input logic [2:0] s, input logic [8:0] o, input string name,
                             input bit use_t = 1'b0);
      exp_t e;
      logic [8:0] a_out;
      logic [2:0] a_st;
      e.st = s; e.out = o; e.name = name;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      if (use_t) begin
         a_out = {t_pcw, t_rw, t_we2, t_rd1, t_rd2, t_rst, t_itk, t_ill, t_flt};
         a_st  = t_st;
      end else begin
         a_out = {pcw, rw, we2, rd1, rd2, rst_o, itk, ill, flt};
         a_st  = st;
      end
      n_chk++;
      if (a_st === e.st && a_out === e.out) n_pass++;
      else $display("FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
                    e.name, a_st, a_out, e.st, e.out);
   endtask

   task automatic cyc(input logic [6:0] op, input logic ir, input logic dr, input logic [1:0] im,
                      input logic [2:0] s, input logic [8:0] o, input string name,
                      input bit use_t = 1'b0);
      opcode = op; imem_ready = ir; dmem_ready = dr; intr = im[1]; mie = im[0];
      expect_now(s, o, name, use_t);
      @(negedge clk);
   endtask

   // Enters and leaves at a falling edge; release leaves the DUT in INIT for the next cycle.
   task automatic reset_dut();
      rst_n = 1'b0;
      expect_now(3'd0, O_INIT, "in_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal;
   end

   initial begin
      rst_n = 1'b0; opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0; intr = 1'b0; mie = 1'b0;
      add(OP_R,   1, 0, 3'd0, O_INIT,  "init");
      add(OP_R,   1, 0, 3'd1, O_FETCH, "fetch0");
      add(OP_R,   1, 0, 3'd2, O_ALU,   "exec_r");
      add(OP_R,   0, 0, 3'd1, O_FETCH, "fwait1");
      add(OP_R,   0, 0, 3'd1, O_FETCH, "fwait2");
      add(OP_R,   0, 0, 3'd1, O_FETCH, "fwait3");
      add(OP_LD,  1, 0, 3'd1, O_FETCH, "fready_on_timeout");
      add(OP_LD,  0, 0, 3'd2, O_LDX,   "exec_ld");
      add(OP_LD,  0, 0, 3'd3, O_LDX,   "mem_ld1");
      add(OP_LD,  0, 0, 3'd3, O_LDX,   "mem_ld2");
      add(OP_LD,  0, 1, 3'd3, O_LDX,   "mem_ld_rdy");
      add(OP_LD,  0, 0, 3'd4, O_ALU,   "wb");
      add(OP_SW,  1, 0, 3'd1, O_FETCH, "fetch_st");
      add(OP_SW,  0, 0, 3'd2, O_STX,   "exec_st");
      add(OP_SW,  0, 1, 3'd3, O_STR,   "mem_st_rdy");
      add(OP_BR,  1, 0, 3'd1, O_FETCH, "fetch_br");
      add(OP_BR,  1, 0, 3'd2, O_BR,    "exec_br");
      add(OP_BAD, 1, 0, 3'd1, O_FETCH, "fetch_bad");
      add(OP_BAD, 1, 0, 3'd2, O_ILL0,  "exec_bad");
      add(OP_LUI, 1, 0, 3'd1, O_FETCH, "fetch_lui");
      add(OP_LUI, 1, 0, 3'd2, O_ALU,   "exec_lui");
      add(OP_LD,  1, 0, 3'd1, O_FETCH, "fetch_ld2");
      add(OP_LD,  0, 0, 3'd2, O_LDX,   "exec_ld2");
      add(OP_LD,  0, 0, 3'd3, O_LDX,   "mto0");
      add(OP_LD,  0, 0, 3'd3, O_LDX,   "mto1");
      add(OP_LD,  0, 0, 3'd3, O_LDX,   "mto2");
      add(OP_LD,  0, 0, 3'd3, O_LDX,   "mto3");
      add(OP_LD,  1, 1, 3'd6, O_TRAP,  "trap_d0");
      add(OP_LD,  1, 1, 3'd6, O_TRAP,  "trap_d1");

      @(negedge clk);
      reset_dut();
      foreach (vecs[i])
         cyc(vecs[i].op, vecs[i].ir, vecs[i].dr, 2'b00, vecs[i].st, vecs[i].out, vecs[i].name);

      // Instruction fetch watchdog: four non-ready cycles, then stuck in TRAP.
      reset_dut();
      cyc(OP_R, 0, 0, 2'b00, 3'd0, O_INIT,  "to_init");
      for (int i = 0; i < 4; i++)
         cyc(OP_R, 0, 0, 2'b00, 3'd1, O_FETCH, "to_fetch");
      cyc(OP_R, 1, 1, 2'b00, 3'd6, O_TRAP, "to_trap0");
      cyc(OP_R, 1, 1, 2'b00, 3'd6, O_TRAP, "to_trap1");
      cyc(OP_R, 1, 1, 2'b00, 3'd6, O_TRAP, "to_trap2");

      // Illegal opcode on the trapping variant.
      reset_dut();
      cyc(OP_BAD, 1, 0, 2'b00, 3'd0, O_INIT,  "t_init", 1'b1);
      cyc(OP_BAD, 1, 0, 2'b00, 3'd1, O_FETCH, "t_fetch", 1'b1);
      cyc(OP_BAD, 1, 0, 2'b00, 3'd2, O_ILL1,  "t_exec_bad", 1'b1);
      cyc(OP_BAD, 1, 0, 2'b00, 3'd6, O_TRAP,  "t_trap", 1'b1);

      // Asynchronous reset in the middle of a store.
      reset_dut();
      cyc(OP_SW, 1, 0, 2'b00, 3'd0, O_INIT,  "ar_init");
      cyc(OP_SW, 1, 0, 2'b00, 3'd1, O_FETCH, "ar_fetch");
      cyc(OP_SW, 0, 0, 2'b00, 3'd2, O_STX,   "ar_exec_st");
      expect_now(3'd3, O_STX, "ar_mem_wait");
      rst_n = 1'b0;
      expect_now(3'd0, O_INIT, "ar_async_drop");
      @(negedge clk);

      // Interrupt sampling at retire only.
      reset_dut();
      cyc(OP_I,  1, 0, 2'b11, 3'd0, O_INIT,  "irq_init");
      cyc(OP_I,  1, 0, 2'b11, 3'd1, O_FETCH, "irq_fetch");
      cyc(OP_I,  1, 0, 2'b11, 3'd2, O_ALU,   "irq_exec_i");
`ifdef CU_FSM_INTR_EN
      cyc(OP_LD, 1, 0, 2'b11, 3'd5, O_INTR,  "irq_entry");
      cyc(OP_LD, 1, 0, 2'b11, 3'd1, O_FETCH, "irq_no_retake");
`else
      cyc(OP_LD, 1, 0, 2'b11, 3'd1, O_FETCH, "irq_ignored");
`endif
      cyc(OP_LD, 0, 0, 2'b11, 3'd2, O_LDX,   "irq_exec_ld");
      cyc(OP_LD, 0, 1, 2'b11, 3'd3, O_LDX,   "irq_mem_no_take");
      cyc(OP_LD, 1, 0, 2'b10, 3'd4, O_ALU,   "irq_wb_masked");
      cyc(OP_R,  1, 0, 2'b11, 3'd1, O_FETCH, "irq_after_masked");
      cyc(OP_R,  1, 0, 2'b11, 3'd2, O_ALU,   "irq_exec_r");
`ifdef CU_FSM_INTR_EN
      cyc(OP_R,  1, 0, 2'b00, 3'd5, O_INTR,  "irq_entry2");
`else
      cyc(OP_R,  1, 0, 2'b00, 3'd1, O_FETCH, "irq_ignored2");
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
